// File: rtl/instr_mem_loader_pkg.sv
// Shared types for the instruction memory loader. The CHECK state only exists
// when INSTR_MEM_LOADER_CHECKSUM_EN is defined.
package instr_mem_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RECV,
    ST_WRITE,
`ifdef INSTR_MEM_LOADER_CHECKSUM_EN
    ST_CHECK,
`endif
    ST_DONE
  } state_e;

  function automatic int bytes_per_word(input int data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/instr_mem_loader_if.sv
// Host-side control, byte stream and instruction-memory write port of the loader.
// master = host/test side, slave = the loader itself.
interface instr_mem_loader_if #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int DATA_WIDTH    = 32
);
  logic                     start;
  logic [ADDRESS_WIDTH:0]   word_count;
  logic                     byte_valid;
  logic [7:0]               byte_data;
  logic                     byte_ready;
  logic                     we;
  logic [ADDRESS_WIDTH-1:0] wa;
  logic [DATA_WIDTH-1:0]    wd;
  logic                     busy;
  logic                     done;
  logic                     cpu_hold;
  logic                     err;

  modport master (
    output start, word_count, byte_valid, byte_data,
    input  byte_ready, we, wa, wd, busy, done, cpu_hold, err
  );

  modport slave (
    input  start, word_count, byte_valid, byte_data,
    output byte_ready, we, wa, wd, busy, done, cpu_hold, err
  );
endinterface

// File: rtl/instr_mem_loader_byte_packer.sv
// Little-endian byte-to-word shift register. word_o already includes the byte
// pushed this cycle so the caller can capture a complete word on the last push.
module byte_packer
  import instr_mem_loader_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clear_i,
  input  logic                  push_i,
  input  logic [7:0]            byte_i,
  output logic [DATA_WIDTH-1:0] word_o,
  output logic                  last_byte_o
);
  localparam int BPW   = bytes_per_word(DATA_WIDTH);
  localparam int IDX_W = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BPW - 1);

  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DATA_WIDTH-1:0] word_q, word_d;

  assign last_byte_o = (idx_q == LAST_IDX);
  assign word_o      = word_d;

  // New bytes enter at the top; after BPW pushes the first byte sits in [7:0].
  always_comb begin
    idx_d  = idx_q;
    word_d = word_q;
    if (clear_i) begin
      idx_d = '0;
    end else if (push_i) begin
      word_d = (word_q >> 8) | (DATA_WIDTH'(byte_i) << (DATA_WIDTH - 8));
      idx_d  = last_byte_o ? '0 : idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      idx_q  <= '0;
      word_q <= '0;
    end else begin
      idx_q  <= idx_d;
      word_q <= word_d;
    end
  end

endmodule

// File: rtl/instr_mem_loader.sv
// Boot loader: streams bytes into instruction memory while holding the CPU in reset.
// Optional trailing checksum byte enabled by defining INSTR_MEM_LOADER_CHECKSUM_EN.
module instr_mem_loader
  import instr_mem_loader_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 8,
  parameter int DATA_WIDTH    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  instr_mem_loader_if.slave bus
);
  localparam logic [ADDRESS_WIDTH:0] MAX_COUNT = {1'b1, {ADDRESS_WIDTH{1'b0}}};

  state_e                   state_q, state_d;
  logic [ADDRESS_WIDTH:0]   count_q, count_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [ADDRESS_WIDTH-1:0] wa_q, wa_d;
  logic [DATA_WIDTH-1:0]    wd_q, wd_d;
  logic                     byte_ready, xfer, last_word;
  logic                     pk_clear, pk_push, pk_last;
  logic [DATA_WIDTH-1:0]    pk_word;
`ifdef INSTR_MEM_LOADER_CHECKSUM_EN
  logic [7:0]               sum_q, sum_d, chk_total;
  logic                     err_q, err_d;
`endif

`ifdef INSTR_MEM_LOADER_CHECKSUM_EN
  assign byte_ready = (state_q == ST_RECV) || (state_q == ST_CHECK);
  assign chk_total  = sum_q + bus.byte_data;
  assign bus.busy   = (state_q == ST_RECV) || (state_q == ST_WRITE) || (state_q == ST_CHECK);
  assign bus.err    = err_q;
`else
  assign byte_ready = (state_q == ST_RECV);
  assign bus.busy   = (state_q == ST_RECV) || (state_q == ST_WRITE);
  assign bus.err    = 1'b0;
`endif

  assign xfer           = bus.byte_valid && byte_ready;
  assign pk_push        = xfer && (state_q == ST_RECV);
  assign last_word      = ({1'b0, addr_q} == (count_q - 1'b1));
  assign bus.byte_ready = byte_ready;
  assign bus.we         = (state_q == ST_WRITE);
  assign bus.wa         = wa_q;
  assign bus.wd         = wd_q;
  assign bus.done       = (state_q == ST_DONE);
  assign bus.cpu_hold   = (state_q != ST_DONE);

  byte_packer #(.DATA_WIDTH(DATA_WIDTH)) u_packer (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .clear_i     (pk_clear),
    .push_i      (pk_push),
    .byte_i      (bus.byte_data),
    .word_o      (pk_word),
    .last_byte_o (pk_last)
  );

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    addr_d   = addr_q;
    wa_d     = wa_q;
    wd_d     = wd_q;
    pk_clear = 1'b0;
`ifdef INSTR_MEM_LOADER_CHECKSUM_EN
    sum_d    = sum_q;
    err_d    = err_q;
`endif
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          count_d  = (bus.word_count > MAX_COUNT) ? MAX_COUNT : bus.word_count;
          addr_d   = '0;
          pk_clear = 1'b1;
`ifdef INSTR_MEM_LOADER_CHECKSUM_EN
          sum_d    = '0;
          err_d    = 1'b0;
`endif
          state_d  = (bus.word_count == '0) ? ST_DONE : ST_RECV;
        end
      end
      ST_RECV: begin
        if (xfer) begin
`ifdef INSTR_MEM_LOADER_CHECKSUM_EN
          sum_d = sum_q + bus.byte_data;
`endif
          // Capture the write port on the last byte so it is stable for the WRITE cycle.
          if (pk_last) begin
            wa_d    = addr_q;
            wd_d    = pk_word;
            state_d = ST_WRITE;
          end
        end
      end
      ST_WRITE: begin
        if (last_word) begin
`ifdef INSTR_MEM_LOADER_CHECKSUM_EN
          state_d = ST_CHECK;
`else
          state_d = ST_DONE;
`endif
        end else begin
          addr_d  = addr_q + 1'b1;
          state_d = ST_RECV;
        end
      end
`ifdef INSTR_MEM_LOADER_CHECKSUM_EN
      ST_CHECK: begin
        if (xfer) begin
          err_d   = (chk_total != 8'h00);
          state_d = ST_DONE;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      addr_q  <= '0;
      wa_q    <= '0;
      wd_q    <= '0;
`ifdef INSTR_MEM_LOADER_CHECKSUM_EN
      sum_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      addr_q  <= addr_d;
      wa_q    <= wa_d;
      wd_q    <= wd_d;
`ifdef INSTR_MEM_LOADER_CHECKSUM_EN
      sum_q   <= sum_d;
      err_q   <= err_d;
`endif
    end
  end

endmodule
